// File: rtl/rf_arbiter.sv
// rtl/rf_arbiter.sv - two-requester register-file arbiter, round-robin with optional grant lock
// Lock hold is compiled in only when RF_ARB_LOCK_EN is defined.
module rf_arbiter #(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          b_req,
  input  logic          a_lock,
  input  logic          b_lock,
  input  logic          a_we,
  input  logic          b_we,
  input  logic [AW-1:0] a_addr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;

  localparam int LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);

  state_t        state_q, state_d, rr_next;
  logic          a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic          last_q, last_d;  // 1 = B served last
  logic          exec_a, exec_b;

`ifdef RF_ARB_LOCK_EN
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          keep;
`else
  logic          unused_lock;
  assign unused_lock = a_lock ^ b_lock ^ LOCK_LAST[0];
`endif

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

  // Register-file port follows the owner combinationally, even while reset is asserted.
  always_comb begin
    exec_a = (state_q == OWN_A) && a_req;
    exec_b = (state_q == OWN_B) && b_req;
    rf_we  = 1'b0;
    rf_wa  = '0;
    rf_ra  = '0;
    rf_wd  = '0;
    if (exec_a) begin
      rf_we = a_we;
      rf_wa = a_addr;
      rf_ra = a_addr;
      rf_wd = a_wdata;
    end else if (exec_b) begin
      rf_we = b_we;
      rf_wa = b_addr;
      rf_ra = b_addr;
      rf_wd = b_wdata;
    end
  end

  always_comb begin
    last_d = last_q;
    if (exec_a) begin
      last_d = 1'b0;
    end else if (exec_b) begin
      last_d = 1'b1;
    end

    if (a_req && b_req) begin
      rr_next = last_d ? OWN_A : OWN_B;
    end else if (a_req) begin
      rr_next = OWN_A;
    end else if (b_req) begin
      rr_next = OWN_B;
    end else begin
      rr_next = IDLE;
    end
    state_d = rr_next;

`ifdef RF_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
    keep       = 1'b0;
    if (state_q == OWN_A) begin
      keep = a_req && a_lock && (lock_cnt_q < LOCK_LAST);
    end else if (state_q == OWN_B) begin
      keep = b_req && b_lock && (lock_cnt_q < LOCK_LAST);
    end
    if (keep) begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q + LW'(1);
    end else if (rr_next != state_q) begin
      lock_cnt_d = '0;
    end
`endif

    a_gnt_d    = (state_d == OWN_A);
    b_gnt_d    = (state_d == OWN_B);
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    if (exec_a && !a_we) begin
      a_rdata_d  = rf_rd;
      a_rvalid_d = 1'b1;
    end
    if (exec_b && !b_we) begin
      b_rdata_d  = rf_rd;
      b_rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      last_q     <= 1'b1;
`ifdef RF_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      last_q     <= last_d;
`ifdef RF_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rf_arbiter.sv
// tb/tb_rf_arbiter.sv - directed bench for rf_arbiter with read-data scoreboard
// Lock-burst expectations follow RF_ARB_LOCK_EN.
module tb_rf_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_req, b_req, a_lock, b_lock, a_we, b_we;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       rf_we;
  logic [2:0] rf_wa, rf_ra;
  logic [7:0] rf_wd, rf_rd;

  logic [7:0] mem [8] = '{default: 8'h00};
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic       exp_a_seq [6];
  logic       exp_b_seq [6];
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  rf_arbiter #(.DW(8), .AW(3), .MAX_LOCK(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .b_req(b_req), .a_lock(a_lock), .b_lock(b_lock),
    .a_we(a_we), .b_we(b_we), .a_addr(a_addr), .b_addr(b_addr),
    .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra(rf_ra), .rf_rd(rf_rd)
  );

  // Register file model: combinational read, write at the edge.
  assign rf_rd = mem[rf_ra];
  always @(posedge clk) if (rf_we === 1'b1) mem[rf_wa] <= rf_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_rvalid === 1'b1) begin
      if (qa.size() == 0) chk("a_rvalid_unexpected", a_rvalid, 0);
      else chk("a_rdata", a_rdata, qa.pop_front());
    end
    if (b_rvalid === 1'b1) begin
      if (qb.size() == 0) chk("b_rvalid_unexpected", b_rvalid, 0);
      else chk("b_rdata", b_rdata, qb.pop_front());
    end
  end

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic gnt_chk(input string tag, input logic ea, input logic eb,
                         input logic [7:0] rda, input logic [7:0] rdb);
    chk({tag, "_a_gnt"}, a_gnt, ea);
    chk({tag, "_b_gnt"}, b_gnt, eb);
    if (ea && a_req && !a_we) qa.push_back(rda);
    if (eb && b_req && !b_we) qb.push_back(rdb);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
    adv;
    adv;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    a_req = 0; b_req = 0; a_lock = 0; b_lock = 0; a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    adv;
    adv;
    at_neg;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wa", rf_wa, 0);
    chk("rst_rf_ra", rf_ra, 0);
    chk("rst_rf_wd", rf_wd, 0);
    adv;
    reset_n = 1'b1;

    // Single write then read of address 3
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'h5A;
    at_neg; gnt_chk("wr_c0", 0, 0, 0, 0); chk("wr_c0_rf_we", rf_we, 0); adv;
    at_neg; gnt_chk("wr_c1", 1, 0, 0, 0);
    chk("wr_c1_rf_we", rf_we, 1); chk("wr_c1_rf_wa", rf_wa, 3); chk("wr_c1_rf_wd", rf_wd, 8'h5A);
    adv;
    a_we = 0;
    at_neg; gnt_chk("rd_c2", 1, 0, 8'h5A, 0);
    chk("rd_c2_rf_we", rf_we, 0); chk("rd_c2_rf_ra", rf_ra, 3);
    adv;
    a_req = 0;
    at_neg; gnt_chk("rd_c3", 1, 0, 0, 0);
    chk("rd_c3_a_rvalid", a_rvalid, 1); chk("rd_c3_rf_ra", rf_ra, 0);
    adv;
    at_neg; gnt_chk("rd_c4", 0, 0, 0, 0);
    chk("rd_c4_a_rvalid", a_rvalid, 0); chk("rd_c4_a_rdata_hold", a_rdata, 8'h5A);
    adv;

    // Simultaneous requests after reset, then reset while B reads
    do_reset;
    a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 3; b_addr = 0;
    at_neg; gnt_chk("sim_c0", 0, 0, 8'h5A, 0); adv;
    at_neg; gnt_chk("sim_c1", 1, 0, 8'h5A, 0); adv;
    at_neg; gnt_chk("sim_c2", 0, 1, 8'h5A, 0); adv;
    at_neg; gnt_chk("sim_c3", 1, 0, 8'h5A, 0); adv;
    reset_n = 0; b_addr = 3;
    at_neg;
    chk("mid_rst_b_gnt", b_gnt, 1); chk("mid_rst_rf_ra", rf_ra, 3); chk("mid_rst_rf_we", rf_we, 0);
    adv;
    reset_n = 1;
    at_neg;
    chk("post_rst_a_gnt", a_gnt, 0); chk("post_rst_b_gnt", b_gnt, 0); chk("post_rst_b_rvalid", b_rvalid, 0);
    adv;
    at_neg; gnt_chk("post_rst_c6", 1, 0, 8'h5A, 0); adv;
    a_req = 0; b_req = 0;
    at_neg; gnt_chk("post_rst_c7", 0, 1, 0, 0); adv;
    at_neg; gnt_chk("post_rst_c8", 0, 0, 0, 0); adv;

    // Same-address hazard on register 5
    a_req = 1; a_we = 1; a_addr = 5; a_wdata = 8'h11;
    at_neg; gnt_chk("hz_c0", 0, 0, 0, 0); adv;
    at_neg; gnt_chk("hz_c1", 1, 0, 0, 0); chk("hz_c1_rf_wd", rf_wd, 8'h11); adv;
    a_wdata = 8'h22;
    at_neg; gnt_chk("hz_c2", 1, 0, 0, 0);
    chk("hz_c2_rf_ra", rf_ra, 5); chk("hz_c2_rf_rd_pre_write", rf_rd, 8'h11); chk("hz_c2_rf_wd", rf_wd, 8'h22);
    adv;
    a_we = 0;
    at_neg; gnt_chk("hz_c3", 1, 0, 8'h22, 0); chk("hz_c3_no_rvalid_after_write", a_rvalid, 0); adv;
    a_req = 0;
    at_neg; gnt_chk("hz_c4", 1, 0, 0, 0); chk("hz_c4_a_rdata", a_rdata, 8'h22); adv;
    at_neg; gnt_chk("hz_c5", 0, 0, 0, 0); adv;

    // A holds req+lock, B holds req
`ifdef RF_ARB_LOCK_EN
    exp_a_seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_b_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_a_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_b_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    do_reset;
    a_req = 1; a_lock = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 5; b_addr = 3;
    for (int i = 0; i < 6; i++) begin
      at_neg;
      gnt_chk($sformatf("lock_c%0d", i), exp_a_seq[i], exp_b_seq[i], 8'h22, 8'h5A);
      adv;
    end
    a_req = 0; b_req = 0; a_lock = 0;
    for (int i = 0; i < 4; i++) adv;
    at_neg;
    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
